// File: rtl/demux4_1_tdm.sv
// demux4_1_tdm: receive side of a 4:1 muxed link.
// A single DATA_LEN-bit beat stream is steered to one of four registered
// channel outputs, either by an explicit channel index (addressed mode) or
// by position within a sync-delimited frame of four beats (TDM mode).
// Each write raises a one-cycle update strobe for its channel. In TDM mode
// a slot-3 write also raises frame_done. A sync arriving mid-frame latches
// a sticky error flag and realigns the frame to slot 0.
module demux4_1_tdm #(
    parameter int DATA_LEN = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [1:0]          ctrl,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_data,
    input  logic                sync,
    input  logic                freeze,
    input  logic                clear_err,
    output logic [DATA_LEN-1:0] out0,
    output logic [DATA_LEN-1:0] out1,
    output logic [DATA_LEN-1:0] out2,
    output logic [DATA_LEN-1:0] out3,
    output logic [3:0]          out_upd,
    output logic                frame_done,
    output logic                sync_err,
    output logic [1:0]          slot
);

    // HUNT: waiting for a sync beat; RUN: locked to the frame.
    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Channel storage, one register per output.
    logic [DATA_LEN-1:0] chan_q [4];

    // Beat accepted at this edge.
    logic       vld_p0;

    // Write decode produced by the output-logic process.
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [1:0] slot_nxt;
    logic       fdone_nxt;
    logic       err_set;

    // Channel index to one-hot update strobe.
    function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
        logic [3:0] oh;
        oh     = 4'b0000;
        oh[ch] = 1'b1;
        return oh;
    endfunction

    // No internal buffering, so readiness is simply the absence of backpressure.
    assign in_ready = ~freeze;
    assign vld_p0   = in_valid & in_ready;

    assign out0 = chan_q[0];
    assign out1 = chan_q[1];
    assign out2 = chan_q[2];
    assign out3 = chan_q[3];

    // State register for the frame-sync FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Addressed mode pins the FSM in HUNT, so re-entering
    // TDM mode always waits for a fresh sync.
    always_comb begin
        state_nxt = state;
        if (!mode) begin
            state_nxt = HUNT;
        end else if (vld_p0 && sync) begin
            state_nxt = RUN;
        end
    end

    // Output logic: which channel to write, where the slot counter goes,
    // and whether this beat closes a frame or reveals a misplaced sync.
    always_comb begin
        wr_en     = 1'b0;
        wr_ch     = 2'd0;
        slot_nxt  = slot;
        fdone_nxt = 1'b0;
        err_set   = 1'b0;
        if (!mode) begin
            slot_nxt = 2'd0;
            if (vld_p0) begin
                wr_en = 1'b1;
                wr_ch = ctrl;
            end
        end else if (vld_p0) begin
            case (state)
                HUNT: begin
                    // Non-sync beats while hunting carry no frame position and are dropped.
                    if (sync) begin
                        wr_en    = 1'b1;
                        wr_ch    = 2'd0;
                        slot_nxt = 2'd1;
                    end
                end
                RUN: begin
                    if (sync) begin
                        // Sync always realigns to ch0; it is an error unless already at slot 0.
                        wr_en    = 1'b1;
                        wr_ch    = 2'd0;
                        slot_nxt = 2'd1;
                        err_set  = (slot != 2'd0);
                    end else begin
                        wr_en     = 1'b1;
                        wr_ch     = slot;
                        slot_nxt  = slot + 2'd1;
                        fdone_nxt = (slot == 2'd3);
                    end
                end
                default: begin
                    wr_en = 1'b0;
                end
            endcase
        end
    end

    // Slot counter; the decode already holds it when no beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= 2'd0;
        end else begin
            slot <= slot_nxt;
        end
    end

    // Channel registers hold their value until their channel is written again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                chan_q[i] <= '0;
            end
        end else if (wr_en) begin
            chan_q[wr_ch] <= in_data;
        end
    end

    // Single-cycle strobes aligned with the newly written channel value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_upd    <= 4'b0000;
            frame_done <= 1'b0;
        end else begin
            out_upd    <= wr_en ? ch_onehot(wr_ch) : 4'b0000;
            frame_done <= fdone_nxt;
        end
    end

    // Sticky sync error; a new error in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err <= 1'b0;
        end else if (err_set) begin
            sync_err <= 1'b1;
        end else if (clear_err) begin
            sync_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux4_1_tdm.sv
// Testbench for demux4_1_tdm: a directed vector table stepped one clock per
// entry, followed by hand-written asynchronous-reset sequences.
module tb_demux4_1_tdm;

    localparam int DATA_LEN = 2;

    logic                clk;
    logic                rst_n;
    logic                mode;
    logic [1:0]          ctrl;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] in_data;
    logic                sync;
    logic                freeze;
    logic                clear_err;
    logic [DATA_LEN-1:0] out0, out1, out2, out3;
    logic [3:0]          out_upd;
    logic                frame_done;
    logic                sync_err;
    logic [1:0]          slot;

    int n_chk  = 0;
    int n_fail = 0;

    demux4_1_tdm #(.DATA_LEN(DATA_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .ctrl       (ctrl),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .sync       (sync),
        .freeze     (freeze),
        .clear_err  (clear_err),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out_upd    (out_upd),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .slot       (slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] ctrl;
        logic       vld;
        logic [1:0] d;
        logic       sync;
        logic       frz;
        logic       clr;
        logic [1:0] e0, e1, e2, e3;
        logic [3:0] eupd;
        logic       efd;
        logic       eerr;
        logic [1:0] eslot;
        logic       erdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic m, input logic [1:0] c, input logic v, input logic [1:0] d,
        input logic s, input logic f, input logic cl,
        input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] e3,
        input logic [3:0] eu, input logic efd, input logic eerr, input logic [1:0] es,
        input logic er);
        vec_t t;
        t.mode = m;  t.ctrl = c;  t.vld = v;  t.d = d;
        t.sync = s;  t.frz = f;   t.clr = cl;
        t.e0 = e0;   t.e1 = e1;   t.e2 = e2;  t.e3 = e3;
        t.eupd = eu; t.efd = efd; t.eerr = eerr; t.eslot = es; t.erdy = er;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag,
        input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] e3,
        input logic [3:0] eu, input logic efd, input logic eerr, input logic [1:0] es,
        input logic er);
        chk({tag, ".out0"},       32'(out0),       32'(e0));
        chk({tag, ".out1"},       32'(out1),       32'(e1));
        chk({tag, ".out2"},       32'(out2),       32'(e2));
        chk({tag, ".out3"},       32'(out3),       32'(e3));
        chk({tag, ".out_upd"},    32'(out_upd),    32'(eu));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(efd));
        chk({tag, ".sync_err"},   32'(sync_err),   32'(eerr));
        chk({tag, ".slot"},       32'(slot),       32'(es));
        chk({tag, ".in_ready"},   32'(in_ready),   32'(er));
    endtask

    task automatic drive(input logic m, input logic [1:0] c, input logic v, input logic [1:0] d,
                         input logic s, input logic f, input logic cl);
        mode = m; ctrl = c; in_valid = v; in_data = d; sync = s; freeze = f; clear_err = cl;
    endtask

    initial begin
        // Addressed mode
        vecs.push_back(mk(0,2,1,3,0,0,0, 0,0,3,0, 4'b0100,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,3,0, 4'b0000,0,0,0,1));
        vecs.push_back(mk(0,0,1,2,0,0,0, 2,0,3,0, 4'b0001,0,0,0,1));
        vecs.push_back(mk(0,1,1,1,0,0,0, 2,1,3,0, 4'b0010,0,0,0,1));
        vecs.push_back(mk(0,3,1,2,0,0,0, 2,1,3,2, 4'b1000,0,0,0,1));
        vecs.push_back(mk(0,2,1,0,0,0,0, 2,1,0,2, 4'b0100,0,0,0,1));
        vecs.push_back(mk(0,2,0,3,0,0,0, 2,1,0,2, 4'b0000,0,0,0,1));
        vecs.push_back(mk(0,0,1,3,0,1,0, 2,1,0,2, 4'b0000,0,0,0,0));
        vecs.push_back(mk(0,1,1,3,1,0,0, 2,3,0,2, 4'b0010,0,0,0,1));
        // TDM full frame, ctrl ignored
        vecs.push_back(mk(1,3,1,1,1,0,0, 1,3,0,2, 4'b0001,0,0,1,1));
        vecs.push_back(mk(1,3,1,2,0,0,0, 1,2,0,2, 4'b0010,0,0,2,1));
        vecs.push_back(mk(1,3,1,3,0,0,0, 1,2,3,2, 4'b0100,0,0,3,1));
        vecs.push_back(mk(1,3,1,0,0,0,0, 1,2,3,0, 4'b1000,1,0,0,1));
        vecs.push_back(mk(1,3,0,0,0,0,0, 1,2,3,0, 4'b0000,0,0,0,1));
        // Back to HUNT via addressed idle, then non-sync beats are dropped
        vecs.push_back(mk(0,0,0,0,0,0,0, 1,2,3,0, 4'b0000,0,0,0,1));
        vecs.push_back(mk(1,0,1,3,0,0,0, 1,2,3,0, 4'b0000,0,0,0,1));
        vecs.push_back(mk(1,1,1,3,0,0,0, 1,2,3,0, 4'b0000,0,0,0,1));
        vecs.push_back(mk(1,2,1,3,0,0,0, 1,2,3,0, 4'b0000,0,0,0,1));
        vecs.push_back(mk(1,0,1,2,1,0,0, 2,2,3,0, 4'b0001,0,0,1,1));
        // Finish frame, then mid-frame sync error, clear vs set, clear
        vecs.push_back(mk(1,0,1,1,0,0,0, 2,1,3,0, 4'b0010,0,0,2,1));
        vecs.push_back(mk(1,0,1,2,0,0,0, 2,1,2,0, 4'b0100,0,0,3,1));
        vecs.push_back(mk(1,0,1,3,0,0,0, 2,1,2,3, 4'b1000,1,0,0,1));
        vecs.push_back(mk(1,0,1,1,1,0,0, 1,1,2,3, 4'b0001,0,0,1,1));
        vecs.push_back(mk(1,0,1,2,0,0,0, 1,2,2,3, 4'b0010,0,0,2,1));
        vecs.push_back(mk(1,0,1,3,1,0,0, 3,2,2,3, 4'b0001,0,1,1,1));
        vecs.push_back(mk(1,0,1,1,1,0,1, 1,2,2,3, 4'b0001,0,1,1,1));
        vecs.push_back(mk(1,0,0,0,0,0,1, 1,2,2,3, 4'b0000,0,0,1,1));
        // Backpressure at slot 2
        vecs.push_back(mk(1,0,1,1,0,0,0, 1,1,2,3, 4'b0010,0,0,2,1));
        vecs.push_back(mk(1,0,1,0,0,1,0, 1,1,2,3, 4'b0000,0,0,2,0));
        vecs.push_back(mk(1,0,1,0,0,1,0, 1,1,2,3, 4'b0000,0,0,2,0));
        vecs.push_back(mk(1,0,1,0,0,0,0, 1,1,0,3, 4'b0100,0,0,3,1));
        vecs.push_back(mk(1,0,1,2,0,0,0, 1,1,0,2, 4'b1000,1,0,0,1));
        vecs.push_back(mk(1,0,1,0,0,0,0, 0,1,0,2, 4'b0001,0,0,1,1));
        vecs.push_back(mk(1,0,1,3,0,0,0, 0,3,0,2, 4'b0010,0,0,2,1));

        // Reset state
        rst_n = 1'b0;
        drive(0,0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0,0,0,0, 4'b0000,0,0,0,1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: inputs set after an edge, checked 1 time unit after the next edge
        foreach (vecs[i]) begin
            drive(vecs[i].mode, vecs[i].ctrl, vecs[i].vld, vecs[i].d,
                  vecs[i].sync, vecs[i].frz, vecs[i].clr);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3,
                    vecs[i].eupd, vecs[i].efd, vecs[i].eerr, vecs[i].eslot, vecs[i].erdy);
        end

        // Async reset between edges while at slot 2 with a sync error pending
        drive(1,0,1,3,1,0,0);
        @(posedge clk);
        #1;
        chk("pre_rst.sync_err", 32'(sync_err), 32'd1);
        chk("pre_rst.slot",     32'(slot),     32'd1);
        drive(1,0,1,2,0,0,0);
        @(posedge clk);
        #1;
        chk("pre_rst.slot2",    32'(slot),     32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0,0,0,0, 4'b0000,0,0,0,1);
        drive(1,0,0,0,0,0,0);
        @(negedge clk);
        rst_n = 1'b1;

        // After reset the FSM hunts: a non-sync beat is dropped
        drive(1,0,1,3,0,0,0);
        @(posedge clk);
        #1;
        chk_all("hunt_drop", 0,0,0,0, 4'b0000,0,0,0,1);
        drive(1,0,1,2,1,0,0);
        @(posedge clk);
        #1;
        chk_all("hunt_sync", 2,0,0,0, 4'b0001,0,0,1,1);
        drive(1,0,1,1,0,0,0);
        @(posedge clk);
        #1;
        chk_all("run_after", 2,1,0,0, 4'b0010,0,0,2,1);

        // Mode 1->0 mid-frame aborts the frame and returns to HUNT
        drive(0,3,1,3,0,0,0);
        @(posedge clk);
        #1;
        chk_all("abort", 2,1,0,3, 4'b1000,0,0,0,1);
        drive(1,0,1,1,0,0,0);
        @(posedge clk);
        #1;
        chk_all("abort_hunt", 2,1,0,3, 4'b0000,0,0,0,1);

        drive(0,0,0,0,0,0,0);
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
